// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, shifts out an 11-bit frame
// on device-generated clock edges, checks the device ACK and reports
// completion or failure with one-cycle pulses. Open-drain pins are
// modelled as separate drive-low outputs; pin levels are read back
// through two-flop synchronisers.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        RTS      = 3'd2,
        SHIFT    = 3'd3,
        ACK_WAIT = 3'd4,
        BUS_IDLE = 3'd5
    } state_t;

    // One counter serves both the inhibit interval and the transfer timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Synchroniser and edge-history flops
    logic clk_meta_r, clk_sync_r, clk_prev_r;
    logic data_meta_r, data_sync_r;
    logic fall_s;

    // FSM and datapath registers
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       edge_cnt_r, edge_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             parity_r, parity_s;
    logic             ack_r, ack_s;
    logic             timeout_s;

    // Registered outputs, loaded from the next-state decode so they line
    // up exactly with the state they belong to.
    logic clk_low_r, clk_low_s;
    logic data_low_r, data_low_s;
    logic ready_r, ready_s;
    logic busy_r, busy_s;
    logic done_r, done_s;
    logic error_r, error_s;

    assign fall_s = clk_prev_r & ~clk_sync_r;
    assign timeout_s = (cnt_r == TIMEOUT_LAST);

    assign tx_ready           = ready_r;
    assign busy               = busy_r;
    assign tx_done            = done_r;
    assign tx_error           = error_r;
    assign ps2_clk_drive_low  = clk_low_r;
    assign ps2_data_drive_low = data_low_r;

    // Bring the asynchronous PS/2 pins into the clk domain; idle level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk_in;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // State, datapath and output registers; reset releases both lines at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            edge_cnt_r <= 4'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            ack_r      <= 1'b0;
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            edge_cnt_r <= edge_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            ack_r      <= ack_s;
            clk_low_r  <= clk_low_s;
            data_low_r <= data_low_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        edge_cnt_s = edge_cnt_r;
        shift_s    = shift_r;
        parity_s   = parity_r;
        ack_s      = ack_r;
        data_low_s = data_low_r;
        done_s     = 1'b0;
        error_s    = 1'b0;

        case (state_r)
            IDLE: begin
                data_low_s = 1'b0;
                if (tx_valid) begin
                    shift_s    = tx_data;
                    parity_s   = odd_parity(tx_data);
                    cnt_s      = CNT_ZERO;
                    edge_cnt_s = 4'd0;
                    ack_s      = 1'b0;
                    state_s    = INHIBIT;
                end else begin
                    state_s    = IDLE;
                end
            end

            INHIBIT: begin
                if (cnt_r == INHIBIT_LAST) begin
                    cnt_s      = CNT_ZERO;
                    data_low_s = 1'b1;
                    state_s    = RTS;
                end else begin
                    cnt_s      = cnt_r + CNT_ONE;
                    data_low_s = 1'b0;
                end
            end

            RTS: begin
                // Data stays low into SHIFT: that low level is the start bit.
                cnt_s      = CNT_ZERO;
                data_low_s = 1'b1;
                state_s    = SHIFT;
            end

            SHIFT: begin
                if (timeout_s) begin
                    cnt_s      = CNT_ZERO;
                    data_low_s = 1'b0;
                    error_s    = 1'b1;
                    state_s    = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (fall_s) begin
                        edge_cnt_s = edge_cnt_r + 4'd1;
                        if (edge_cnt_r < 4'd8) begin
                            data_low_s = ~shift_r[edge_cnt_r[2:0]];
                        end else if (edge_cnt_r == 4'd8) begin
                            data_low_s = ~parity_r;
                        end else begin
                            // Tenth edge: release the line as the stop bit.
                            data_low_s = 1'b0;
                            state_s    = ACK_WAIT;
                        end
                    end else begin
                        edge_cnt_s = edge_cnt_r;
                    end
                end
            end

            ACK_WAIT: begin
                data_low_s = 1'b0;
                if (timeout_s) begin
                    cnt_s   = CNT_ZERO;
                    error_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (fall_s) begin
                        ack_s   = ~data_sync_r;
                        state_s = BUS_IDLE;
                    end else begin
                        ack_s   = ack_r;
                    end
                end
            end

            BUS_IDLE: begin
                // Further clock edges here are ignored; only a fully idle bus ends the transfer.
                data_low_s = 1'b0;
                if (timeout_s) begin
                    cnt_s   = CNT_ZERO;
                    error_s = 1'b1;
                    state_s = IDLE;
                end else if (clk_sync_r && data_sync_r) begin
                    cnt_s   = CNT_ZERO;
                    done_s  = ack_r;
                    error_s = ~ack_r;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                cnt_s      = CNT_ZERO;
                data_low_s = 1'b0;
                state_s    = IDLE;
            end
        endcase

        clk_low_s = (state_s == INHIBIT) || (state_s == RTS);
        ready_s   = (state_s == IDLE);
        busy_s    = (state_s != IDLE);
    end

endmodule
